ifm_fetch_ctrl: RTL and testbench

- Read-side sequencer directly downstream of the IFM BRAM.
- Walks a 2-D tile of IFM words (rows x words-per-row, programmable row stride) and issues word-aligned byte addresses with a read strobe to the BRAM.
- Captures the BRAM read data and buffers it in a small FIFO.
- Presents the data to the GEMM array over a valid/ready stream; issue is credit-limited so the FIFO never overflows.

---
 rtl/ifm_fetch_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_ifm_fetch_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifm_fetch_ctrl.sv
// ifm_fetch_ctrl: read-side sequencer for the IFM BRAM.
// Walks a rows x words-per-row tile with a programmable row stride. It issues
// word-aligned byte reads and captures the returned words in a small FIFO. It
// streams the words out over valid/ready. Reads are issued only against
// free FIFO credit, so the FIFO can never overflow.
// Optional build macro: IFM_FETCH_STALL_CNT_EN adds the stall_cycles counter.
//
// Stream handshake: a word transfers on every clock edge where
// out_valid && out_ready. out_valid depends only on FIFO occupancy and never
// on out_ready. out_data is stable while out_valid is high and no pop occurs.
// out_ready while out_valid is low has no effect.
module ifm_fetch_ctrl #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int CNT_WIDTH     = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]     row_words,
  input  logic [CNT_WIDTH-1:0]     num_rows,
  input  logic [ADDRESS_WIDTH-1:0] row_stride,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] ifm_address,
  output logic                     ifm_address_valid,
  output logic                     write_en,
  input  logic [DATA_WIDTH-1:0]    ifm_data,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               fsm_state
`ifdef IFM_FETCH_STALL_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]     stall_cycles
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W+1:0] DEPTH_L = (PTR_W+2)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Latched tile description
  logic [CNT_WIDTH-1:0]     row_words_q;
  logic [CNT_WIDTH-1:0]     num_rows_q;
  logic [ADDRESS_WIDTH-1:0] stride_q;

  // Walk position
  logic [ADDRESS_WIDTH-1:0] row_base_q;
  logic [CNT_WIDTH-1:0]     col_q;
  logic [CNT_WIDTH-1:0]     row_q;

  // One read outstanding at most per cycle of latency
  logic                     inflight_q;
  logic [ADDRESS_WIDTH-1:0] hold_addr_q;

  // FIFO storage
  logic [DATA_WIDTH-1:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q;
  logic [PTR_W-1:0]         rd_ptr_q;
  logic [PTR_W:0]           count_q;
  logic [PTR_W:0]           count_d;

  logic                     start_acc;
  logic                     zero_size;
  logic                     push;
  logic                     pop;
  logic [PTR_W+1:0]         used;
  logic                     credit_ok;
  logic                     issue;
  logic                     col_last;
  logic                     row_last;
  logic                     last_issue;
  logic [ADDRESS_WIDTH-1:0] issue_addr;

  // Datapath decode: credit, issue decision and the address of this issue
  always_comb begin
    start_acc  = (state_q == S_IDLE) && start;
    zero_size  = (row_words == '0) || (num_rows == '0);
    push       = inflight_q;
    pop        = (count_q != '0) && out_ready;
    used       = {1'b0, count_q} + (PTR_W+2)'(inflight_q);
    // A pop this cycle frees a slot for the word that returns next cycle
    credit_ok  = (used < DEPTH_L) || pop;
    issue      = (state_q == S_FETCH) && credit_ok;
    col_last   = (col_q == row_words_q - CNT_WIDTH'(1));
    row_last   = (row_q == num_rows_q - CNT_WIDTH'(1));
    last_issue = issue && col_last && row_last;
    issue_addr = row_base_q + (ADDRESS_WIDTH'(col_q) << 2);
    count_d    = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = zero_size ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        if (last_issue) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!inflight_q && (count_d == '0)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy              = (state_q == S_FETCH) || (state_q == S_DRAIN);
    done              = (state_q == S_DONE);
    ifm_address_valid = issue;
    ifm_address       = issue ? issue_addr : hold_addr_q;
    write_en          = 1'b0;
    out_valid         = (count_q != '0);
    out_data          = mem_q[rd_ptr_q];
    fsm_state         = state_q;
  end

  // Tile latch and address walk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_words_q <= '0;
      num_rows_q  <= '0;
      stride_q    <= '0;
      row_base_q  <= '0;
      col_q       <= '0;
      row_q       <= '0;
    end else if (start_acc) begin
      row_words_q <= row_words;
      num_rows_q  <= num_rows;
      stride_q    <= row_stride;
      row_base_q  <= base_addr & ~ADDRESS_WIDTH'(3);
      col_q       <= '0;
      row_q       <= '0;
    end else if (issue) begin
      if (col_last) begin
        col_q      <= '0;
        row_q      <= row_q + CNT_WIDTH'(1);
        row_base_q <= row_base_q + stride_q;
      end else begin
        col_q <= col_q + CNT_WIDTH'(1);
      end
    end
  end

  // In-flight tracking and last-address hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q  <= 1'b0;
      hold_addr_q <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) hold_addr_q <= issue_addr;
    end
  end

  // Output FIFO: returning read data is written the cycle after its strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= ifm_data;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

`ifdef IFM_FETCH_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] stall_q;

  // Saturating count of FETCH cycles that were starved of credit
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                   stall_q <= '0;
    else if (start_acc)                                        stall_q <= '0;
    else if ((state_q == S_FETCH) && !issue && (stall_q != '1)) stall_q <= stall_q + CNT_WIDTH'(1);
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_ifm_fetch_ctrl.sv
// Directed bench for ifm_fetch_ctrl with a one-cycle-latency BRAM responder,
// expected address/word queues, and a final pass count.
module tb_ifm_fetch_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] row_words;
  logic [CW-1:0] num_rows;
  logic [AW-1:0] row_stride;
  logic          busy;
  logic          done;
  logic [AW-1:0] ifm_address;
  logic          ifm_address_valid;
  logic          write_en;
  logic [DW-1:0] ifm_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    fsm_state;
`ifdef IFM_FETCH_STALL_CNT_EN
  logic [CW-1:0] stall_cycles;
`endif

  ifm_fetch_ctrl #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH(DW),
    .CNT_WIDTH(CW),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .row_words(row_words),
    .num_rows(num_rows),
    .row_stride(row_stride),
    .busy(busy),
    .done(done),
    .ifm_address(ifm_address),
    .ifm_address_valid(ifm_address_valid),
    .write_en(write_en),
    .ifm_data(ifm_data),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .fsm_state(fsm_state)
`ifdef IFM_FETCH_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int cyc = 0;
  int start_cyc, done_cyc, first_cyc, last_cyc;
  int strobe_cnt, done_cnt, word_cnt;
  bit busy_seen, s_busy, s_done;
  bit rd_v;
  logic [AW-1:0] rd_a;

  function automatic logic [DW-1:0] bram(input logic [AW-1:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    strobe_cnt = 0;
    done_cnt   = 0;
    word_cnt   = 0;
    busy_seen  = 0;
    s_done     = 0;
    s_busy     = 0;
    first_cyc  = 0;
    last_cyc   = 0;
    done_cyc   = 0;
  endtask

  task automatic push_tile(input logic [AW-1:0] base, input int rw, input int nr,
                           input logic [AW-1:0] stride);
    logic [AW-1:0] a;
    for (int r = 0; r < nr; r++) begin
      for (int c = 0; c < rw; c++) begin
        a = base + stride * AW'(r) + AW'(4 * c);
        exp_addr_q.push_back(a);
        exp_q.push_back(bram(a));
      end
    end
  endtask

  // One clock: sample mid-cycle, then answer the BRAM read one cycle later
  task automatic tick();
    @(negedge clk);
    cyc++;
    s_busy = busy;
    s_done = done;
    if (busy) busy_seen = 1;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (ifm_address_valid) begin
      if (strobe_cnt == 0) first_cyc = cyc;
      last_cyc = cyc;
      strobe_cnt++;
      check("strobe_expected", 64'(exp_addr_q.size() != 0), 64'd1);
      if (exp_addr_q.size() != 0) check("ifm_address", ifm_address, exp_addr_q.pop_front());
    end
    if (out_valid && out_ready) begin
      word_cnt++;
      check("word_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("out_data", out_data, exp_q.pop_front());
    end
    rd_v = ifm_address_valid;
    rd_a = ifm_address;
    @(posedge clk);
    #1;
    ifm_data = rd_v ? bram(rd_a) : 32'hBAD0_BAD0;
  endtask

  task automatic do_start(input logic [AW-1:0] base, input logic [CW-1:0] rw,
                          input logic [CW-1:0] nr, input logic [AW-1:0] stride);
    base_addr  = base;
    row_words  = rw;
    num_rows   = nr;
    row_stride = stride;
    start      = 1'b1;
    tick();
    start_cyc  = cyc;
    start      = 1'b0;
    // Scramble the tile inputs; the DUT must use its latched copy
    base_addr  = 32'hDEAD_BEE0;
    row_words  = 16'd7;
    num_rows   = 16'd5;
    row_stride = 32'h0000_1000;
  endtask

  task automatic run_until_done(input int budget);
    int k;
    k = 0;
    while (!s_done && k < budget) begin
      tick();
      k++;
    end
    check("done_seen", 64'(s_done), 64'd1);
  endtask

  // Directed stimulus
  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; row_words = '0; num_rows = '0;
    row_stride = '0; out_ready = 1'b1; ifm_data = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr_valid", ifm_address_valid, 0);
    check("rst_addr", ifm_address, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_write_en", write_en, 0);
    check("rst_state", fsm_state, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // Basic tile, consumer always ready
    clear_stats();
    push_tile(32'h100, 3, 2, 32'h40);
    do_start(32'h100, 16'd3, 16'd2, 32'h40);
    check("t1_busy_in_start_cycle", s_busy, 0);
    tick();
    check("t1_busy_next_cycle", s_busy, 1);
    run_until_done(40);
    check("t1_done_latency", done_cyc - start_cyc, 9);
    check("t1_strobes", strobe_cnt, 6);
    check("t1_first_strobe", first_cyc - start_cyc, 1);
    check("t1_strobe_span", last_cyc - first_cyc, 5);
    check("t1_words", word_cnt, 6);
    check("t1_words_left", exp_q.size(), 0);
    check("t1_addrs_left", exp_addr_q.size(), 0);
    tick(); tick();
    check("t1_single_done", done_cnt, 1);
    check("t1_idle_busy", s_busy, 0);
    check("t1_addr_hold", ifm_address, 32'h148);
    check("t1_addr_hold_valid", ifm_address_valid, 0);

    // Backpressure: consumer stalled for the start cycle plus nine more
    clear_stats();
    push_tile(32'h100, 3, 2, 32'h40);
    out_ready = 1'b0;
    do_start(32'h100, 16'd3, 16'd2, 32'h40);
    repeat (9) tick();
    check("t2_strobes_stalled", strobe_cnt, 4);
    check("t2_words_stalled", word_cnt, 0);
    out_ready = 1'b1;
    tick();
`ifdef IFM_FETCH_STALL_CNT_EN
    check("t2_stall_cycles", stall_cycles, 5);
`endif
    run_until_done(40);
    check("t2_strobes", strobe_cnt, 6);
    check("t2_words", word_cnt, 6);
    check("t2_words_left", exp_q.size(), 0);
    check("t2_single_done", done_cnt, 1);

    // Zero-size tile
    clear_stats();
    do_start(32'h500, 16'd3, 16'd0, 32'h40);
    run_until_done(10);
    check("t3_done_latency", done_cyc - start_cyc, 1);
    check("t3_strobes", strobe_cnt, 0);
    check("t3_busy_seen", busy_seen, 0);

    // Address wrap past the top of the address space
    clear_stats();
    push_tile(32'hFFFF_FFF8, 4, 1, 32'h10);
    do_start(32'hFFFF_FFF8, 16'd4, 16'd1, 32'h10);
    run_until_done(30);
    check("t4_strobes", strobe_cnt, 4);
    check("t4_words", word_cnt, 4);
    check("t4_addrs_left", exp_addr_q.size(), 0);
    check("t4_done_latency", done_cyc - start_cyc, 7);

    // Reset with two words buffered and one read outstanding
    clear_stats();
    push_tile(32'h600, 3, 2, 32'h40);
    out_ready = 1'b0;
    do_start(32'h600, 16'd3, 16'd2, 32'h40);
    repeat (3) tick();
    check("t5_strobes_before_rst", strobe_cnt, 3);
    check("t5_out_valid_before_rst", out_valid, 1);
    rst = 1'b1;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_addr_valid", ifm_address_valid, 0);
    check("t5_rst_addr", ifm_address, 0);
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_out_data", out_data, 0);
    exp_q.delete();
    exp_addr_q.delete();
    tick(); tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    clear_stats();
    push_tile(32'h700, 1, 1, 32'h40);
    do_start(32'h700, 16'd1, 16'd1, 32'h40);
    run_until_done(20);
    tick(); tick();
    check("t5_strobes_after", strobe_cnt, 1);
    check("t5_words_after", word_cnt, 1);
    check("t5_words_left", exp_q.size(), 0);
    check("t5_single_done", done_cnt, 1);

    // Start pulsed during FETCH must be ignored
    clear_stats();
    push_tile(32'h800, 3, 2, 32'h20);
    do_start(32'h800, 16'd3, 16'd2, 32'h20);
    tick();
    base_addr = 32'h900;
    row_words = 16'd2;
    num_rows  = 16'd2;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    run_until_done(30);
    check("t6_done_latency", done_cyc - start_cyc, 9);
    repeat (5) tick();
    check("t6_strobes", strobe_cnt, 6);
    check("t6_words", word_cnt, 6);
    check("t6_addrs_left", exp_addr_q.size(), 0);
    check("t6_single_done", done_cnt, 1);
    check("t6_idle_state", fsm_state, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
